// File: rtl/dma_wb_master.sv
// Single-channel DMA engine: moves words between a stream and RAM through a
// classic Wishbone master port, decoupled by a small data FIFO.
module dma_wb_master #(
    parameter int unsigned LEN_W      = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start,
    input  logic             dir,
    input  logic [31:0]      base_adr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [31:0]      s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [31:0]      m_tdata,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [31:0]      wbm_dat_i
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADR_W  = 32;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_FILL, S_WR_REQ, S_RD_REQ, S_RD_DRAIN, S_FIN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_dir;
    logic [ADR_W-1:0]   r_base;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_issued;
    logic [LEN_W-1:0]   r_accepted;
    logic               r_gap;
    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_ack;
    logic               w_last;
    logic               w_s_hs;
    logic               w_m_hs;
    logic               w_push;
    logic               w_pop;
    logic               w_push_ok;
    logic               w_pop_ok;
    logic [DATA_W-1:0]  w_head;
    logic [DATA_W-1:0]  w_push_data;

    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_ack       = wbm_ack_i & wbm_stb_o;
    assign w_last      = ((r_issued + LEN_W'(1)) == r_len);
    assign w_s_hs      = s_tvalid & s_tready;
    assign w_m_hs      = m_tvalid & m_tready;
    assign w_push      = w_s_hs | (w_ack & (r_state == S_RD_REQ));
    assign w_pop       = w_m_hs | (w_ack & (r_state == S_WR_REQ));
    assign w_push_ok   = w_push & (!w_full | w_pop);
    assign w_pop_ok    = w_pop & !w_empty;
    assign w_push_data = r_dir ? wbm_dat_i : s_tdata;

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) w_state_nxt = S_FIN;
                    else if (dir)  w_state_nxt = S_RD_REQ;
                    else           w_state_nxt = S_WR_FILL;
                end
            end
            S_WR_FILL:  if (!w_empty) w_state_nxt = S_WR_REQ;
            S_WR_REQ:   if (w_ack) w_state_nxt = w_last ? S_FIN : S_WR_FILL;
            S_RD_REQ:   if (w_ack && w_last) w_state_nxt = S_RD_DRAIN;
            // Leave as the final beat pops so done lands one cycle after it
            S_RD_DRAIN: if (w_empty || ((r_count == CNT_W'(1)) && w_pop_ok)) w_state_nxt = S_FIN;
            S_FIN:      w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state; r_gap forces the post-ack idle cycle in read mode
    always_comb begin
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_FIN);
        wbm_stb_o = (r_state == S_WR_REQ) ||
                    ((r_state == S_RD_REQ) && !r_gap && !w_full);
        wbm_cyc_o = wbm_stb_o;
        wbm_we_o  = (r_state == S_WR_REQ);
        wbm_sel_o = wbm_stb_o ? 4'hF : 4'h0;
        wbm_adr_o = wbm_stb_o ? (r_base + ADR_W'({r_issued, 2'b00})) : '0;
        wbm_dat_o = wbm_we_o ? w_head : '0;
        s_tready  = ((r_state == S_WR_FILL) || (r_state == S_WR_REQ)) &&
                    !w_full && (r_accepted < r_len);
        m_tvalid  = ((r_state == S_RD_REQ) || (r_state == S_RD_DRAIN)) && !w_empty;
        m_tdata   = r_dir ? w_head : '0;
    end

    // Command latch, counters and FIFO storage
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_dir      <= 1'b0;
            r_base     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_accepted <= '0;
            r_gap      <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_dir      <= dir;
                r_base     <= base_adr & 32'hFFFF_FFFC;
                r_len      <= len;
                r_issued   <= '0;
                r_accepted <= '0;
            end else begin
                if (w_ack)  r_issued   <= r_issued + LEN_W'(1);
                if (w_s_hs) r_accepted <= r_accepted + LEN_W'(1);
            end
            r_gap <= w_ack;
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= w_push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
        end
    end

endmodule

// File: doc/dma_wb_master.md
# dma_wb_master

Single-channel DMA engine acting as the DMA-side Wishbone master feeding the CPU/DMA RAM arbiter. On a start command it either moves `len` 32-bit words from an input stream into RAM (write mode) or from RAM to an output stream (read mode), one classic Wishbone transaction at a time. A 4-entry data FIFO decouples stream handshakes from arbitration stalls.

## Interface
Parameters:
- `LEN_W`, 10: width of the transfer length in words; maximum transfer is 2^LEN_W−1 words.
- `FIFO_DEPTH`, 4: data FIFO entries; must be a power of two, minimum 2.

Ports:
- `wb_clk_i`  in  1  clock
- `wb_rst_i`  in  1  reset, asynchronous, active-high
- `start`  in  1  one-cycle command strobe; ignored while `busy`
- `dir`  in  1  0 = stream→RAM (write), 1 = RAM→stream (read); sampled with `start`
- `base_adr`  in  32  byte address of the first word; sampled with `start`; bits [1:0] forced to 0
- `len`  in  LEN_W  word count; sampled with `start`
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle completion pulse
- `s_tvalid` / `s_tready` / `s_tdata`  in / out / in  1/1/32  input stream, write mode only
- `m_tvalid` / `m_tready` / `m_tdata`  out / in / out  1/1/32  output stream, read mode only
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1  Wishbone master controls
- `wbm_sel_o`  out  4  always 4'hF during a transaction
- `wbm_adr_o`, `wbm_dat_o`  out  32  address, write data
- `wbm_ack_i`  in  1  acknowledge from the arbiter
- `wbm_dat_i`  in  32  read data, valid with `wbm_ack_i`

## Operation
- States: IDLE, WR_FILL, WR_REQ, RD_REQ, RD_DRAIN, FIN.
- IDLE: on `start` with `len`≠0, latch `dir`, `base_adr`, `len`, and clear the issue and accept counters. Go to WR_FILL if `dir`=0, else RD_REQ. On `start` with `len`=0, go to FIN; no bus activity.
- Write mode:
  - `s_tready` = busy & !dir & FIFO not full & accepted < len. Beats beyond `len` are never accepted.
  - WR_FILL: when the FIFO is non-empty, go to WR_REQ.
  - WR_REQ: `cyc`, `stb` and `we` are high; `dat_o` is the FIFO head; `adr_o` = base + 4·issued.
  - On ack: pop the FIFO and increment `issued`. If issued = len, go to FIN; otherwise go to WR_FILL.
- Read mode:
  - RD_REQ: requires FIFO free space ≥1 before `stb` rises. If the FIFO is full, stay with `cyc`/`stb` low.
  - On ack: push `wbm_dat_i` and increment `issued`. If issued = len, go to RD_DRAIN.
  - `m_tvalid` = FIFO non-empty; `m_tdata` = FIFO head.
  - RD_DRAIN: wait for the FIFO to empty, then go to FIN.
- FIN: `done`=1 for one cycle, `busy` drops, return to IDLE.
- Bus rules:
  - Once `stb` rises, `adr`, `dat`, `we` and `sel` are held stable until the sampled ack.
  - `cyc`/`stb` are low for at least one cycle after every ack, so the arbiter can re-arbitrate.
  - `wbm_ack_i` is ignored while `stb`=0.
- Address arithmetic is modulo 2^32 (wraps past 0xFFFF_FFFC). Counters are LEN_W bits.
- FIFO: simultaneous push and pop when full or empty is legal; occupancy stays consistent. Pointers wrap modulo FIFO_DEPTH.
- Reset at any time, including mid-transaction: FIFO flushed, counters zeroed, state IDLE, `cyc`/`stb` low immediately.

## Timing
- Reset value of every output is 0: `busy`, `done`, `s_tready`, `m_tvalid`, `m_tdata`, and all `wbm_*_o`.
- All outputs are registered or decoded from registered state only; there is no combinational path from `wbm_ack_i` to any Wishbone output.
- `start` at edge N: `busy`=1 from cycle N+1.
  - Read mode: `stb` high in cycle N+1.
  - Write mode: `stb` high one cycle after the first FIFO push.
- Ack sampled at edge k: `stb` low in cycle k+1. The next request may rise in cycle k+2, giving at best 1 word per 2 cycles.
- Read data pushed at ack edge k: `m_tvalid` high in cycle k+1.
- Last ack (write) or last `m_tready`&`m_tvalid` beat (read) at edge k: `done`=1 in cycle k+1 and `busy`=0 in cycle k+2.
- Arbiter stalls of any length are tolerated; `stb` and the request fields stay held.

## Test plan
- Write, len=3, base=0x100, stream words A,B,C, ack 1 cycle after each `stb` → writes 0x100=A, 0x104=B, 0x108=C; `sel`=F; `done` pulse; a 4th offered beat is never accepted.
- Read, len=5, base=0x200, `m_tready` held low → exactly 4 reads issued, then `stb` stays low; raising `m_tready` yields all 5 words in order, then `done`.
- Ack delayed 7 cycles (CPU holding the arbiter) → `adr`/`dat`/`we` stable throughout; exactly one transfer; `stb` low the cycle after ack.
- len=0 start → `done` 1 cycle after start; `cyc` never asserted.
- Base 0xFFFF_FFF8, len=3 read → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Reset asserted while `stb` high in write mode → `cyc`/`stb`/`busy` 0 immediately; a new start afterwards behaves as from power-up.
